// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the native valid/ready memory bus.
// One request is in flight at a time; the grant is held until the slave
// completes, the granted master aborts, or the watchdog forces completion.
// Every completion is followed by a one-cycle turnaround so the master can
// drop valid before the next arbitration.
module mem_bus_arbiter #(
  parameter bit          FIXED_PRIO     = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_valid_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_wstrb_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_ready_o,
  input  logic        m1_valid_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_wstrb_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_ready_o,
  output logic        s_valid_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic [3:0]  s_wstrb_o,
  input  logic [31:0] s_rdata_i,
  input  logic        s_ready_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  // Watchdog counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int unsigned    WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit             WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;   // one-hot owner, bit 0 = master 0
  logic            last_q, last_d;     // 1 = master 1 completed most recently
  logic [WD_W-1:0] wd_q, wd_d;
  logic            g_valid;
  logic            wd_hit;
  logic            rdy;
  logic [31:0]     rdat;

  assign g_valid = grant_q[1] ? m1_valid_i : m0_valid_i;
  assign wd_hit  = WD_EN && (wd_q == WD_LAST);

  // Control registers: state, owner, round-robin history and watchdog.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  // Arbitration, bus muxing, completion routing and watchdog next-state.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    wd_d      = wd_q;
    s_valid_o = 1'b0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    s_wstrb_o = '0;
    grant_o   = 2'b00;
    timeout_o = 1'b0;
    rdy       = 1'b0;
    rdat      = '0;

    unique case (state_q)
      IDLE: begin
        wd_d = '0;
        if (m0_valid_i && m1_valid_i) begin
          // Contended: master 0 under fixed priority, else whoever did not go last.
          grant_d = (FIXED_PRIO || last_q) ? 2'b01 : 2'b10;
          state_d = BUSY;
        end else if (m0_valid_i) begin
          grant_d = 2'b01;
          state_d = BUSY;
        end else if (m1_valid_i) begin
          grant_d = 2'b10;
          state_d = BUSY;
        end
      end
      BUSY: begin
        grant_o   = grant_q;
        s_valid_o = g_valid;
        s_addr_o  = grant_q[1] ? m1_addr_i  : m0_addr_i;
        s_wdata_o = grant_q[1] ? m1_wdata_i : m0_wdata_i;
        s_wstrb_o = grant_q[1] ? m1_wstrb_i : m0_wstrb_i;
        if (!g_valid) begin
          // Master withdrew its request: release the bus silently.
          state_d = IDLE;
          grant_d = 2'b00;
          wd_d    = '0;
        end else if (s_ready_i) begin
          rdy     = 1'b1;
          rdat    = s_rdata_i;
          last_d  = grant_q[1];
          state_d = DONE;
        end else if (wd_hit) begin
          // Hung slave: withdraw the request and complete with a marker value.
          s_valid_o = 1'b0;
          timeout_o = 1'b1;
          rdy       = 1'b1;
          rdat      = TIMEOUT_RDATA;
          last_d    = grant_q[1];
          state_d   = DONE;
        end else if (WD_EN) begin
          wd_d = wd_q + 1'b1;
        end
      end
      DONE: begin
        grant_d = 2'b00;
        wd_d    = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = 2'b00;
        wd_d    = '0;
        state_d = IDLE;
      end
    endcase

    m0_ready_o = rdy & grant_q[0];
    m1_ready_o = rdy & grant_q[1];
    m0_rdata_o = (rdy & grant_q[0]) ? rdat : '0;
    m1_rdata_o = (rdy & grant_q[1]) ? rdat : '0;
  end

endmodule
